// File: rtl/m3_step_pkg.sv
// Shared types and default constants for the 3-phase commutation step sequencer.
package m3_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int unsigned STEP_NUM_DEF   = 12;
  localparam int unsigned CALC_STEP_DEF  = 10;
  localparam int unsigned PERIOD_MAX_DEF = 32'h003F_FFFF;
  localparam int unsigned TRIM_W         = 8;

endpackage

// File: rtl/m3_slice_timer.sv
// Slice-length down-counter with zero-length clamp; optional speed trim under M3_STEP_SPEED_TRIM_EN.
module m3_slice_timer
  import m3_step_pkg::*;
#(
  parameter int unsigned      CNT_W      = 22,
  parameter logic [CNT_W-1:0] PERIOD_MAX = '1
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             load_max_i,
  input  logic             load_len_i,
  input  logic             count_i,
  input  logic [CNT_W-1:0] len_raw_i,
`ifdef M3_STEP_SPEED_TRIM_EN
  input  logic             round_done_i,
  input  logic             speed_inc_i,
  input  logic             speed_dec_i,
`endif
  output logic             last_cyc_o
);

  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CNT_W-1:0] len;

`ifdef M3_STEP_SPEED_TRIM_EN
  logic signed [TRIM_W-1:0] trim_q, trim_d;
  logic signed [CNT_W+1:0]  len_sum;

  always_comb begin
    trim_d = trim_q;
    if (round_done_i && (speed_inc_i ^ speed_dec_i)) begin
      if (speed_inc_i && (trim_q != -TRIM_W'(127)))
        trim_d = trim_q - TRIM_W'(1);
      else if (speed_dec_i && (trim_q != TRIM_W'(127)))
        trim_d = trim_q + TRIM_W'(1);
    end
  end

  // The load coinciding with a round wrap already uses the updated trim.
  always_comb begin
    len     = CNT_W'(1);
    len_sum = signed'({2'b00, len_raw_i}) + (CNT_W+2)'(trim_d);
    if (len_sum[CNT_W+1] || (len_sum == '0))
      len = CNT_W'(1);
    else if (len_sum[CNT_W])
      len = '1;
    else
      len = len_sum[CNT_W-1:0];
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) trim_q <= '0;
    else        trim_q <= trim_d;
  end
`else
  always_comb begin
    len = (len_raw_i == '0) ? CNT_W'(1) : len_raw_i;
  end
`endif

  always_comb begin
    remain_d = remain_q;
    if (load_max_i)
      remain_d = PERIOD_MAX;
    else if (load_len_i)
      remain_d = len;
    else if (count_i)
      remain_d = remain_q - CNT_W'(1);
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) remain_q <= PERIOD_MAX;
    else        remain_q <= remain_d;
  end

  assign last_cyc_o = (remain_q == CNT_W'(1));

endmodule

// File: rtl/m3_step_seq_param.sv
// Parametrised bidirectional commutation step sequencer with graceful drain.
// Optional speed trim inputs are present when M3_STEP_SPEED_TRIM_EN is defined.
module m3_step_seq_param
  import m3_step_pkg::*;
#(
  parameter int unsigned      STEP_NUM   = STEP_NUM_DEF,
  parameter int unsigned      CNT_W      = 22,
  parameter logic [CNT_W-1:0] PERIOD_MAX = CNT_W'(PERIOD_MAX_DEF),
  parameter int unsigned      CALC_STEP  = CALC_STEP_DEF,
  parameter int unsigned      STEP_W     = $clog2(STEP_NUM)
) (
  input  logic              clkI,
  input  logic              nRstI,
  input  logic              m3startI,
  input  logic              m3forceStopI,
  input  logic              m3invRotateI,
  input  logic [31:0]       dstRoundLenI,
`ifdef M3_STEP_SPEED_TRIM_EN
  input  logic              m3speedINCi,
  input  logic              m3speedDECi,
`endif
  output logic              workingO,
  output logic [STEP_W-1:0] stepO,
  output logic              stepStrobeO,
  output logic              roundDoneO,
  output logic              nextCalc_1o
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_NUM - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              last_cyc, working, wrap;
  logic              tmr_load_max, tmr_load_len, tmr_count;
  logic              step_strobe, round_done;
  logic              unused_len_hi;

  assign unused_len_hi = ^dstRoundLenI[31:CNT_W];

  m3_slice_timer #(
    .CNT_W      (CNT_W),
    .PERIOD_MAX (PERIOD_MAX)
  ) u_timer (
    .clkI         (clkI),
    .nRstI        (nRstI),
    .load_max_i   (tmr_load_max),
    .load_len_i   (tmr_load_len),
    .count_i      (tmr_count),
    .len_raw_i    (dstRoundLenI[CNT_W-1:0]),
`ifdef M3_STEP_SPEED_TRIM_EN
    .round_done_i (round_done),
    .speed_inc_i  (m3speedINCi),
    .speed_dec_i  (m3speedDECi),
`endif
    .last_cyc_o   (last_cyc)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    tmr_load_max = 1'b0;
    tmr_load_len = 1'b0;
    tmr_count    = 1'b0;
    step_strobe  = 1'b0;
    round_done   = 1'b0;
    working      = (state_q == RUN) || (state_q == DRAIN);
    wrap         = m3invRotateI ? (step_q == '0) : (step_q == LAST_STEP);
    if (m3forceStopI) begin
      state_d      = IDLE;
      step_d       = '0;
      tmr_load_max = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tmr_load_max = 1'b1;
          if (m3startI) state_d = PRE;
        end
        PRE: begin
          tmr_count = 1'b1;
          if (last_cyc) begin
            state_d      = RUN;
            tmr_load_len = 1'b1;
            step_strobe  = 1'b1;
            step_d       = m3invRotateI ? LAST_STEP : '0;
          end
        end
        RUN, DRAIN: begin
          tmr_count = 1'b1;
          if (last_cyc) begin
            tmr_load_len = 1'b1;
            step_strobe  = 1'b1;
            round_done   = wrap;
            if (m3invRotateI) step_d = wrap ? LAST_STEP : step_q - STEP_W'(1);
            else              step_d = wrap ? '0 : step_q + STEP_W'(1);
          end
          // Drain ends only on the wrap edge; a returning start resumes seamlessly.
          if (m3startI) begin
            state_d = RUN;
          end else if ((state_q == DRAIN) && last_cyc && wrap) begin
            state_d      = IDLE;
            step_d       = '0;
            tmr_load_len = 1'b0;
            tmr_load_max = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign workingO    = working;
  assign stepO       = step_q;
  assign stepStrobeO = step_strobe;
  assign roundDoneO  = round_done;
  assign nextCalc_1o = last_cyc & working & (step_q == STEP_W'(CALC_STEP));

endmodule
